// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and helpers for the clkdiv_bank clock divider slice.
package clkdiv_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int DIV_W_DEF   = 16;
  localparam int DIV_RST_DEF = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Channel-select width; never below one bit so a single-channel bank keeps its port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// clkdiv_ch: one divider channel with counter, active/pending divisor and run/stop control.
// Divisor changes land only at a falling boundary (or at once when stopped/halted/aligned).
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_q_r;
  logic [DIV_W-1:0] pdiv_r;
  logic             pend_r;
  logic             clk_r;
  logic             tick_r;

  logic running_s;
  logic boundary_s;
  logic align_s;
  logic apply_s;

  // A high phase always runs out even when disabled, so a pulse is never cut short.
  always_comb begin
    running_s  = (div_q_r != DIV_ZERO) && (en_i || clk_r);
    boundary_s = running_s && (cnt_r == (div_q_r - DIV_ONE));
    align_s    = sync_i && en_i;
    apply_s    = pend_r && ((boundary_s && clk_r) || !running_s || align_s);
  end

  // Counter, divided clock and tick; every restart point parks at count 0 with clock low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r  <= DIV_ZERO;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else if (apply_s || align_s || !running_s) begin
      cnt_r  <= DIV_ZERO;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else if (boundary_s) begin
      cnt_r  <= DIV_ZERO;
      clk_r  <= ~clk_r;
      tick_r <= ~clk_r;
    end else begin
      cnt_r  <= cnt_r + DIV_ONE;
      clk_r  <= clk_r;
      tick_r <= 1'b0;
    end
  end

  // Divisor staging: a write waits in pdiv_r until the channel reaches a safe apply point.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q_r <= DIV_W'(DIV_RST);
      pdiv_r  <= DIV_ZERO;
      pend_r  <= 1'b0;
    end else if (apply_s) begin
      div_q_r <= pdiv_r;
      pdiv_r  <= pdiv_r;
      pend_r  <= 1'b0;
    end else if (wr_i) begin
      div_q_r <= div_q_r;
      pdiv_r  <= wr_div_i;
      pend_r  <= 1'b1;
    end else begin
      div_q_r <= div_q_r;
      pdiv_r  <= pdiv_r;
      pend_r  <= pend_r;
    end
  end

  assign pend_o = pend_r;
  assign clk_o  = clk_r;
  assign tick_o = tick_r;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NUM_CH runtime-programmable clock dividers with tick strobes and one config port.
// Define CLKDIV_SYNC_EN to add sync_i, which phase-aligns every enabled channel.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH  = NUM_CH_DEF,
  parameter int  DIV_W   = DIV_W_DEF,
  parameter int  DIV_RST = DIV_RST_DEF,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic              sync_i
`endif
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic              ch_ok_s;
  logic              hs_s;
  logic              sync_s;
  logic [NUM_CH-1:0] wr_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync_i;
`else
  assign sync_s = 1'b0;
`endif

  // Ready mirrors the addressed channel's pending flag; unknown channels accept and drop.
  always_comb begin
    ch_ok_s = ({1'b0, cfg_ch_i} < NUM_CH_L);
    if (ch_ok_s) begin
      cfg_ready_o = ~pend_o[cfg_ch_i];
    end else begin
      cfg_ready_o = 1'b1;
    end
    hs_s = cfg_valid_i & cfg_ready_o;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_s[i] = hs_s & (cfg_ch_i == CH_W'(i));

    clkdiv_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[i]),
      .sync_i   (sync_s),
      .wr_i     (wr_s[i]),
      .wr_div_i (cfg_div_i),
      .pend_o   (pend_o[i]),
      .clk_o    (clk_o[i]),
      .tick_o   (tick_o[i])
    );
  end

endmodule

// File: doc/clkdiv_bank.md
# clkdiv_bank

Multi-channel, runtime-programmable clock divider bank generating NUM_CH independent divided clocks and matching single-cycle tick strobes from one input clock. Each channel's divisor is reloaded through a valid/ready configuration port; new divisors take effect only at a period boundary, so no output pulse is ever truncated. The block sits between the system clock and the protocol encoders and bit-timers that need slower clocks or clock enables.

## Interface
- NUM_CH, 4, number of divider channels (1..16)
- DIV_W, 16, divisor width in bits
- DIV_RST, 2, divisor loaded into every channel at reset (nonzero, < 2**DIV_W)
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  NUM_CH  per-channel run enable
- cfg_valid_i  in  1  divisor write request
- cfg_ready_o  out  1  write accepted when valid and ready both high
- cfg_ch_i  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div_i  in  DIV_W  new divisor
- pend_o  out  NUM_CH  per-channel divisor update pending
- clk_o  out  NUM_CH  divided clocks, period 2*div input cycles, 50 % duty
- tick_o  out  NUM_CH  one-cycle strobe, high in the cycle clk_o rises
- sync_i  in  1  phase-align strobe (only with CLKDIV_SYNC_EN)

## Operation
- Reset: clk_o=0, tick_o=0, pend_o=0, counters=0, active divisor div_q=DIV_RST, cfg_ready_o=1.
- Per channel: counter counts 0..div_q-1 while running; at count==div_q-1 it wraps to 0 and clk_o toggles (boundary). tick_o=1 in the cycle clk_o goes 0->1.
- div_q==0: channel halted, counter held 0, clk_o held 0.
- div_q==1: clk_o toggles every cycle (period 2 input cycles), tick_o high every second cycle.
- Config: cfg_ready_o = !pend_o[cfg_ch_i]. Handshake stores cfg_div_i in channel pending register, sets pend_o. cfg_ch_i >= NUM_CH: accepted and dropped.
- Apply: pending divisor moves to div_q at the next falling boundary (clk_o 1->0), or in the next cycle if the channel is stopped or div_q==0; counter resets to 0, pend_o clears the same cycle. A new request for that channel is accepted from the following cycle.
- Disable (en_i low): a channel with clk_o=1 runs to its falling boundary, then stops; with clk_o=0 it stops immediately. Stopped: counter 0, clk_o 0.
- Enable: counting starts from 0; first rising edge of clk_o div_q cycles after en_i is seen high.
- Simultaneous apply and disable on one cycle: divisor applied, channel stops.

## Timing
- All outputs registered; no combinational path input->clk_o/tick_o.
- cfg_ready_o is combinational from cfg_ch_i and pend_o.
- Update latency: at most 2*div_q_old cycles from handshake to div_q change.
- Reset mid-operation: all channels return to reset state asynchronously; pending writes are lost.

## Configuration
- CLKDIV_SYNC_EN defined: sync_i port exists; sync_i high for one cycle forces every enabled channel to counter=0, clk_o=0 next cycle (also applies any pending divisor); all channels with equal div_q are then phase-aligned.
- Not defined: no sync_i port, no alignment logic; channels run freely.

## Structure
- Package clkdiv_pkg: div_t (logic [DIV_W-1:0]) default width constant, DIV_RST default.
- Sub-module clkdiv_ch: one channel (counter, div_q, pending register, enable/stop logic); clkdiv_bank instantiates NUM_CH copies and decodes the config port.

## Test plan
- Reset, en_i=all ones, DIV_RST=2 -> each clk_o period 4 cycles, first rise 2 cycles after enable, tick_o every 4 cycles.
- Write ch1 div=5 while clk_o[1] high -> pend_o[1]=1, ready low for ch1, change at next fall, then period 10; high phase before change not shortened.
- Write ch0 div=0 -> clk_o[0] stays 0 after next fall, tick_o[0] never asserts; write div=3 -> restarts, first rise 3 cycles after apply.
- Drop en_i[2] one cycle after clk_o[2] rises (div=4) -> clk_o[2] stays high 4 cycles total, then 0 and holds.
- Back-to-back writes to ch3 -> second held off (cfg_ready_o=0) until pend_o[3] clears; writes to ch0 accepted meanwhile.
- CLKDIV_SYNC_EN: ch0/ch1 div=3 with offset phases, pulse sync_i -> both clk_o identical afterwards.
